// File: rtl/pwm_multi.sv
// N-channel PWM: shared prescaler and period counter (edge or center aligned),
// double-buffered per-channel duty, and an active-low 7-segment duty readout.
module pwm_multi #(
    parameter int N_CH     = 4,
    parameter int CNT_W    = 8,
    parameter int PERIOD   = 10,
    parameter int PRESCALE = 2,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             center,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [CNT_W-1:0] wr_duty,
    input  logic [CH_W-1:0]  disp_ch,
    output logic [N_CH-1:0]  pwm,
    output logic             period_tick,
    output logic [7:0]       out_display
);

    localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int NIB_W = (CNT_W >= 4) ? 4 : CNT_W;

    localparam logic [PS_W-1:0]  PS_MAX  = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0]  PS_ONE  = PS_W'(1);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    // Active-low {g,f,e,d,c,b,a} glyphs for one hex digit.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'h40;
            4'h1:    g = 7'h79;
            4'h2:    g = 7'h24;
            4'h3:    g = 7'h30;
            4'h4:    g = 7'h19;
            4'h5:    g = 7'h12;
            4'h6:    g = 7'h02;
            4'h7:    g = 7'h78;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h10;
            4'hA:    g = 7'h08;
            4'hB:    g = 7'h03;
            4'hC:    g = 7'h46;
            4'hD:    g = 7'h21;
            4'hE:    g = 7'h06;
            4'hF:    g = 7'h0E;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    logic [PS_W-1:0]  psc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             dir_down_r;
    logic             mode_act_r;
    logic [CNT_W-1:0] duty_pend_r [N_CH];
    logic [CNT_W-1:0] duty_act_r  [N_CH];
    logic [N_CH-1:0]  pwm_r;
    logic             period_tick_r;
    logic [7:0]       out_display_r;

    logic             tick_s;
    logic             boundary_s;
    logic             wr_ok_s;
    logic [PS_W-1:0]  psc_nx_s;
    logic [CNT_W-1:0] cnt_nx_s;
    logic             dir_down_nx_s;
    logic [N_CH-1:0]  pwm_nx_s;
    logic [3:0]       disp_nib_s;
    logic [7:0]       disp_nx_s;

    assign tick_s  = en && (psc_r == PS_MAX);
    assign wr_ok_s = wr_en && (32'(wr_ch) < N_CH);

    // Prescaler next value: free-runs 0..PRESCALE-1 while enabled.
    always_comb begin
        psc_nx_s = psc_r;
        if (tick_s) begin
            psc_nx_s = {PS_W{1'b0}};
        end else begin
            psc_nx_s = psc_r + PS_ONE;
        end
    end

    // Counter/direction next state and period boundary detection.
    always_comb begin
        cnt_nx_s      = cnt_r;
        dir_down_nx_s = dir_down_r;
        boundary_s    = 1'b0;
        if (!tick_s) begin
            boundary_s = 1'b0;
        end else if (!mode_act_r) begin
            if (cnt_r >= CNT_TOP) begin
                boundary_s = 1'b1;
            end else begin
                cnt_nx_s = cnt_r + CNT_ONE;
            end
        end else if (dir_down_r) begin
            if (cnt_r <= CNT_ONE) begin
                boundary_s = 1'b1;
            end else begin
                cnt_nx_s = cnt_r - CNT_ONE;
            end
        end else if (cnt_r >= CNT_TOP) begin
            // With PERIOD=2 the top is already 1, so there is no down leg.
            if (CNT_TOP == CNT_ONE) begin
                boundary_s = 1'b1;
            end else begin
                dir_down_nx_s = 1'b1;
                cnt_nx_s      = cnt_r - CNT_ONE;
            end
        end else begin
            cnt_nx_s = cnt_r + CNT_ONE;
        end
        if (boundary_s) begin
            cnt_nx_s      = CNT_ZERO;
            dir_down_nx_s = 1'b0;
        end else begin
            dir_down_nx_s = dir_down_nx_s;
        end
    end

    // Per-channel compare against the active duty.
    always_comb begin
        pwm_nx_s = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            pwm_nx_s[i] = en && (cnt_r < duty_act_r[i]);
        end
    end

    // Display digit: top nibble of the selected channel's active duty.
    always_comb begin
        if (32'(disp_ch) < N_CH) begin
            disp_nib_s = 4'(duty_act_r[disp_ch][CNT_W-1 -: NIB_W]);
            disp_nx_s  = {~en, hex_glyph(disp_nib_s)};
        end else begin
            disp_nib_s = 4'h0;
            disp_nx_s  = {~en, 7'h3F};
        end
    end

    // Timebase registers; held at their reset values while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc_r      <= {PS_W{1'b0}};
            cnt_r      <= CNT_ZERO;
            dir_down_r <= 1'b0;
        end else if (!en) begin
            psc_r      <= {PS_W{1'b0}};
            cnt_r      <= CNT_ZERO;
            dir_down_r <= 1'b0;
        end else begin
            psc_r      <= psc_nx_s;
            cnt_r      <= cnt_nx_s;
            dir_down_r <= dir_down_nx_s;
        end
    end

    // Duty double buffer and mode latch; transfer reads the pre-write pending value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_act_r <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                duty_pend_r[i] <= CNT_ZERO;
                duty_act_r[i]  <= CNT_ZERO;
            end
        end else begin
            if (wr_ok_s) begin
                duty_pend_r[wr_ch] <= wr_duty;
            end
            if (!en || boundary_s) begin
                mode_act_r <= center;
                for (int i = 0; i < N_CH; i++) begin
                    duty_act_r[i] <= duty_pend_r[i];
                end
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_r         <= {N_CH{1'b0}};
            period_tick_r <= 1'b0;
            out_display_r <= 8'hC0;
        end else begin
            pwm_r         <= pwm_nx_s;
            period_tick_r <= boundary_s;
            out_display_r <= disp_nx_s;
        end
    end

    assign pwm         = pwm_r;
    assign period_tick = period_tick_r;
    assign out_display = out_display_r;

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: per-cycle scoreboard against a position-based
// model, a display vector table, and period/duty measurements for the corner cases.
module tb_pwm_multi;

    localparam int N_CH     = 4;
    localparam int CNT_W    = 8;
    localparam int PERIOD   = 10;
    localparam int PRESCALE = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       center;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_duty;
    logic [1:0] disp_ch;
    logic [3:0] pwm;
    logic       period_tick;
    logic [7:0] out_display;

    always #5 clk = ~clk;

    pwm_multi #(
        .N_CH(N_CH), .CNT_W(CNT_W), .PERIOD(PERIOD), .PRESCALE(PRESCALE)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .center(center),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty), .disp_ch(disp_ch),
        .pwm(pwm), .period_tick(period_tick), .out_display(out_display)
    );

    int checks = 0;
    int errors = 0;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct packed {
        logic [3:0] pwm;
        logic       tick;
        logic [7:0] disp;
    } exp_t;

    typedef struct {
        logic [1:0] ch;
        logic [7:0] duty;
        logic [1:0] disp;
        logic       en_v;
        logic [7:0] exp_disp;
    } disp_vec_t;

    exp_t sb_q[$];

    int         m_pos;
    logic       m_mode;
    logic [7:0] m_pend [4];
    logic [7:0] m_act  [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int m_cnt(input int pos, input logic mode);
        int t;
        t = pos / PRESCALE;
        if (mode && (t > PERIOD - 1)) t = 2 * (PERIOD - 1) - t;
        return t;
    endfunction

    function automatic logic m_bnd();
        int plen;
        plen = m_mode ? 2 * (PERIOD - 1) * PRESCALE : PERIOD * PRESCALE;
        return en && (m_pos == plen - 1);
    endfunction

    function automatic exp_t m_expect();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.pwm[i] = en && (m_cnt(m_pos, m_mode) < int'(m_act[i]));
        end
        e.tick = m_bnd();
        e.disp = {~en, glyph[m_act[disp_ch][7:4]]};
        return e;
    endfunction

    // Reference model: period position in clk cycles, expectations queued per edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pos  <= 0;
            m_mode <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_pend[i] <= 8'h00;
                m_act[i]  <= 8'h00;
            end
            sb_q.delete();
        end else begin
            sb_q.push_back(m_expect());
            if (!en || m_bnd()) begin
                for (int i = 0; i < 4; i++) m_act[i] <= m_pend[i];
                m_mode <= center;
                m_pos  <= 0;
            end else begin
                m_pos <= m_pos + 1;
            end
            if (wr_en) m_pend[wr_ch] <= wr_duty;
        end
    end

    // Scoreboard: compare DUT outputs on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_pwm", 32'(pwm), 32'(4'h0));
            chk("rst_tick", 32'(period_tick), 32'(1'b0));
            chk("rst_disp", 32'(out_display), 32'(8'hC0));
        end else if (sb_q.size() != 0) begin
            chk("sb_pwm", 32'(pwm), 32'(sb_q[0].pwm));
            chk("sb_tick", 32'(period_tick), 32'(sb_q[0].tick));
            chk("sb_disp", 32'(out_display), 32'(sb_q[0].disp));
            void'(sb_q.pop_front());
        end
    end

    task automatic write_ch(input logic [1:0] ch, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_duty = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_tick(output bit found);
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (period_tick) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // One period from just after a tick sample up to and including the next tick sample.
    task automatic measure(input int w1_at, input logic [7:0] w1_val,
                           input int w2_at, input logic [7:0] w2_val,
                           output int len, output int highs,
                           output logic [3:0] ors, output logic [3:0] ands);
        bit done;
        len   = 0;
        highs = 0;
        ors   = 4'h0;
        ands  = 4'hF;
        done  = 1'b0;
        while (!done && len < 200) begin
            if (len == w1_at) begin
                wr_en = 1'b1; wr_ch = 2'd0; wr_duty = w1_val;
            end else if (len == w2_at) begin
                wr_en = 1'b1; wr_ch = 2'd0; wr_duty = w2_val;
            end else begin
                wr_en = 1'b0;
            end
            @(negedge clk);
            len++;
            if (pwm[0]) highs++;
            ors  = ors | pwm;
            ands = ands & pwm;
            if (period_tick) done = 1'b1;
        end
        wr_en = 1'b0;
    endtask

    initial begin
        disp_vec_t  vec [16];
        bit         found;
        int         len;
        int         highs;
        logic [3:0] ors;
        logic [3:0] ands;
        logic [3:0] ors_t;
        logic [3:0] ands_t;

        vec[0]  = '{2'd1, 8'hA5, 2'd1, 1'b1, 8'h08};
        vec[1]  = '{2'd1, 8'hA5, 2'd1, 1'b0, 8'h88};
        vec[2]  = '{2'd0, 8'h9C, 2'd1, 1'b0, 8'h88};
        vec[3]  = '{2'd2, 8'h3C, 2'd2, 1'b0, 8'hB0};
        vec[4]  = '{2'd3, 8'hF0, 2'd3, 1'b1, 8'h0E};
        vec[5]  = '{2'd0, 8'h7F, 2'd0, 1'b0, 8'hF8};
        vec[6]  = '{2'd2, 8'hD2, 2'd2, 1'b1, 8'h21};
        vec[7]  = '{2'd0, 8'hB4, 2'd0, 1'b1, 8'h03};
        vec[8]  = '{2'd3, 8'hC0, 2'd3, 1'b0, 8'hC6};
        vec[9]  = '{2'd1, 8'hE1, 2'd1, 1'b1, 8'h06};
        vec[10] = '{2'd2, 8'h2F, 2'd2, 1'b0, 8'hA4};
        vec[11] = '{2'd3, 8'h64, 2'd3, 1'b1, 8'h02};
        vec[12] = '{2'd0, 8'h10, 2'd0, 1'b0, 8'hF9};
        vec[13] = '{2'd1, 8'h45, 2'd1, 1'b1, 8'h19};
        vec[14] = '{2'd2, 8'h58, 2'd2, 1'b0, 8'h92};
        vec[15] = '{2'd3, 8'h80, 2'd3, 1'b1, 8'h00};

        rst = 1'b1; en = 1'b0; center = 1'b0; wr_en = 1'b0;
        wr_ch = 2'd0; wr_duty = 8'h00; disp_ch = 2'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_disp", 32'(out_display), 32'(8'hC0));

        for (int r = 0; r < 16; r++) begin
            en = 1'b0;
            write_ch(vec[r].ch, vec[r].duty);
            disp_ch = vec[r].disp;
            @(negedge clk);
            en = vec[r].en_v;
            @(negedge clk);
            chk($sformatf("disp_vec%0d", r), 32'(out_display), 32'(vec[r].exp_disp));
            en = 1'b0;
        end

        for (int c = 0; c < 4; c++) write_ch(2'(c), 8'h00);
        disp_ch = 2'd0;
        repeat (2) @(negedge clk);
        chk("cleared_disp", 32'(out_display), 32'(8'hC0));

        // Edge mode, ch0 = 3.
        en = 1'b1;
        write_ch(2'd0, 8'd3);
        wait_tick(found);
        chk("t2_tick_seen", 32'(found), 32'(1'b1));
        measure(-1, 8'h00, -1, 8'h00, len, highs, ors, ands);
        chk("t2_period", 32'(len), 32'(20));
        chk("t2_high", 32'(highs), 32'(6));
        measure(-1, 8'h00, -1, 8'h00, len, highs, ors, ands);
        chk("t2_period2", 32'(len), 32'(20));

        // Duty extremes on channels 1..3.
        write_ch(2'd1, 8'd0);
        write_ch(2'd2, 8'd10);
        write_ch(2'd3, 8'd255);
        wait_tick(found);
        chk("t3_tick_seen", 32'(found), 32'(1'b1));
        ors_t  = 4'h0;
        ands_t = 4'hF;
        for (int p = 0; p < 3; p++) begin
            measure(-1, 8'h00, -1, 8'h00, len, highs, ors, ands);
            ors_t  = ors_t | ors;
            ands_t = ands_t & ands;
            chk("t3_period", 32'(len), 32'(20));
        end
        chk("t3_ch1_stuck0", 32'(ors_t[1]), 32'(1'b0));
        chk("t3_ch2_stuck1", 32'(ands_t[2]), 32'(1'b1));
        chk("t3_ch3_stuck1", 32'(ands_t[3]), 32'(1'b1));

        // Mid-period write 7, then write 5 in the boundary cycle.
        measure(5, 8'd7, 19, 8'd5, len, highs, ors, ands);
        chk("t4_len_a", 32'(len), 32'(20));
        chk("t4_high_a", 32'(highs), 32'(6));
        measure(-1, 8'h00, -1, 8'h00, len, highs, ors, ands);
        chk("t4_high_b", 32'(highs), 32'(14));
        measure(-1, 8'h00, -1, 8'h00, len, highs, ors, ands);
        chk("t4_high_c", 32'(highs), 32'(10));

        // Switch to center-aligned with ch0 = 3.
        center = 1'b1;
        measure(3, 8'd3, -1, 8'h00, len, highs, ors, ands);
        chk("t5_last_edge_len", 32'(len), 32'(20));
        chk("t5_last_edge_high", 32'(highs), 32'(10));
        for (int p = 0; p < 2; p++) begin
            measure(-1, 8'h00, -1, 8'h00, len, highs, ors, ands);
            chk("t5_center_len", 32'(len), 32'(36));
            chk("t5_center_high", 32'(highs), 32'(10));
        end

        // Asynchronous reset in the middle of a period.
        repeat (7) @(negedge clk);
        chk("t1_pre_rst_pwm3", 32'(pwm[3]), 32'(1'b1));
        #2;
        rst = 1'b1;
        en  = 1'b0;
        #1;
        chk("t1_async_pwm", 32'(pwm), 32'(4'h0));
        chk("t1_async_tick", 32'(period_tick), 32'(1'b0));
        chk("t1_async_disp", 32'(out_display), 32'(8'hC0));
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        center = 1'b0;
        repeat (3) @(negedge clk);
        chk("t1_post_disp", 32'(out_display), 32'(8'hC0));
        chk("t1_post_pwm", 32'(pwm), 32'(4'h0));
        write_ch(2'd0, 8'd4);
        @(negedge clk);
        en = 1'b1;
        measure(-1, 8'h00, -1, 8'h00, len, highs, ors, ands);
        chk("t1_resume_len", 32'(len), 32'(20));
        chk("t1_resume_high", 32'(highs), 32'(8));

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
